// File: rtl/wb_commit.sv
// wb_commit: writeback/commit stage. It holds the 32x32 architectural
// register file and retires at most one instruction per cycle. It takes
// precise exceptions by capturing the faulting PC and address, entering
// supervisor mode, flushing the younger pipeline stages and redirecting fetch
// to the handler. An iret returns fetch to the saved epc.
module wb_commit #(
    parameter logic [31:0] HANDLER_VECTOR = 32'h0000_8000,
    parameter int unsigned DRAIN_CYCLES   = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic [31:0] wb_result,
    input  logic [31:0] wb_read_data,
    input  logic [4:0]  wb_rd,
    input  logic        wb_mem_to_reg,
    input  logic        wb_reg_write,
    input  logic        wb_exception,
    input  logic [31:0] wb_faulty_address,
    input  logic [31:0] wb_pc,
    input  logic        iret,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic [31:0] ebadaddr,
    output logic        supervisor
);

    // The counter only has to hold DRAIN_CYCLES-1. Keep it at least one bit wide.
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic [31:0]        regs [32];

    logic               is_idle;
    logic               exc_accept;
    logic               iret_accept;
    logic               wr_en;
    logic [31:0]        wr_data;

    logic               flush_d;
    logic               redirect_valid_d;
    logic [31:0]        redirect_pc_d;
    logic [31:0]        epc_d;
    logic [31:0]        ebadaddr_d;
    logic               supervisor_d;

    // Retire qualification. Any slot that arrives while a redirect is in
    // progress belongs to a squashed path and has no effect.
    always_comb begin
        is_idle     = (state_q == ST_IDLE);
        exc_accept  = is_idle && wb_valid && wb_exception;
        // An exception in the same cycle wins and the iret is dropped.
        iret_accept = is_idle && iret && supervisor && !exc_accept;
        wr_en       = is_idle && wb_valid && wb_reg_write && !wb_exception
                      && (wb_rd != 5'd0);
        wr_data     = wb_mem_to_reg ? wb_read_data : wb_result;
    end

    // Register file storage. r0 is never written, so it holds its reset zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every entry must read zero after reset, so the array is
            // built from resettable flops and cannot be mapped to a RAM macro.
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wb_rd] <= wr_data;
        end
    end

    // Read port 1. When the same register is being written this cycle, the
    // write data is bypassed.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != 5'd0) begin
            rs1_data = (wr_en && (rs1_addr == wb_rd)) ? wr_data : regs[rs1_addr];
        end
    end

    // Read port 2 works the same way as read port 1.
    always_comb begin
        rs2_data = '0;
        if (rs2_addr != 5'd0) begin
            rs2_data = (wr_en && (rs2_addr == wb_rd)) ? wr_data : regs[rs2_addr];
        end
    end

    // Next-state logic for the redirect sequence: IDLE -> FLUSH -> DRAIN* -> IDLE.
    always_comb begin
        // NOTE: each signal gets a default before the case statement, so no
        // path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (exc_accept || iret_accept) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (DRAIN_CYCLES == 1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs. They are computed from the next
    // state, so an exception seen at edge N drives flush in cycle N+1.
    always_comb begin
        flush_d          = (state_d != ST_IDLE);
        redirect_valid_d = (state_d == ST_FLUSH);
        redirect_pc_d    = redirect_pc;
        epc_d            = epc;
        ebadaddr_d       = ebadaddr;
        supervisor_d     = supervisor;
        if (exc_accept) begin
            redirect_pc_d = HANDLER_VECTOR;
            epc_d         = wb_pc;
            ebadaddr_d    = wb_faulty_address;
            supervisor_d  = 1'b1;
        end else if (iret_accept) begin
            redirect_pc_d = epc;
            supervisor_d  = 1'b0;
        end
    end

    // FSM state and drain counter. Reset aborts a drain in progress immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state is assigned with <= so that every flop
            // samples values from before the edge, whatever the statement order.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered exception and redirect outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            epc            <= '0;
            ebadaddr       <= '0;
            supervisor     <= 1'b0;
        end else begin
            flush          <= flush_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            epc            <= epc_d;
            ebadaddr       <= ebadaddr_d;
            supervisor     <= supervisor_d;
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Directed testbench for wb_commit. The expected values are computed by hand
// from the intended behaviour: register writes and bypass, load select,
// exception capture, iret return, exception/iret collision and reset mid-drain.
module tb_wb_commit;

    logic        clock;
    logic        reset_n;
    logic        wb_valid;
    logic [31:0] wb_result;
    logic [31:0] wb_read_data;
    logic [4:0]  wb_rd;
    logic        wb_mem_to_reg;
    logic        wb_reg_write;
    logic        wb_exception;
    logic [31:0] wb_faulty_address;
    logic [31:0] wb_pc;
    logic        iret;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [31:0] ebadaddr;
    logic        supervisor;

    int errors = 0;
    int checks = 0;

    wb_commit #(
        .HANDLER_VECTOR (32'h0000_8000),
        .DRAIN_CYCLES   (3)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .wb_valid          (wb_valid),
        .wb_result         (wb_result),
        .wb_read_data      (wb_read_data),
        .wb_rd             (wb_rd),
        .wb_mem_to_reg     (wb_mem_to_reg),
        .wb_reg_write      (wb_reg_write),
        .wb_exception      (wb_exception),
        .wb_faulty_address (wb_faulty_address),
        .wb_pc             (wb_pc),
        .iret              (iret),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .epc               (epc),
        .ebadaddr          (ebadaddr),
        .supervisor        (supervisor)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stop a runaway simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        wb_valid          = 1'b0;
        wb_result         = '0;
        wb_read_data      = '0;
        wb_rd             = '0;
        wb_mem_to_reg     = 1'b0;
        wb_reg_write      = 1'b0;
        wb_exception      = 1'b0;
        wb_faulty_address = '0;
        wb_pc             = '0;
        iret              = 1'b0;
    endtask

    task automatic drive_write(input logic [4:0] rd, input logic m2r,
                               input logic [31:0] result, input logic [31:0] rdata);
        clear_inputs();
        wb_valid      = 1'b1;
        wb_reg_write  = 1'b1;
        wb_rd         = rd;
        wb_mem_to_reg = m2r;
        wb_result     = result;
        wb_read_data  = rdata;
    endtask

    task automatic drive_exc(input logic [31:0] pc, input logic [31:0] addr,
                             input logic [4:0] rd);
        clear_inputs();
        wb_valid          = 1'b1;
        wb_exception      = 1'b1;
        wb_reg_write      = 1'b1;
        wb_rd             = rd;
        wb_result         = 32'hBAD0_BAD0;
        wb_pc             = pc;
        wb_faulty_address = addr;
    endtask

    initial begin
        clear_inputs();
        rs1_addr = 5'd5;
        rs2_addr = 5'd7;
        reset_n  = 1'b0;
        #12;
        check("reset_flush", 32'(flush), 32'd0);
        check("reset_redirect_valid", 32'(redirect_valid), 32'd0);
        check("reset_redirect_pc", redirect_pc, 32'h0);
        check("reset_epc", epc, 32'h0);
        check("reset_ebadaddr", ebadaddr, 32'h0);
        check("reset_supervisor", 32'(supervisor), 32'd0);
        check("reset_r5", rs1_data, 32'h0);
        reset_n = 1'b1;
        tick();

        // Test 1: write r5, bypass in the same cycle, then read back.
        drive_write(5'd5, 1'b0, 32'hDEAD_BEEF, 32'h0);
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        #1;
        check("bypass_r5", rs1_data, 32'hDEAD_BEEF);
        check("r0_port2", rs2_data, 32'h0);
        tick();
        clear_inputs();
        #1;
        check("readback_r5", rs1_data, 32'hDEAD_BEEF);
        drive_write(5'd0, 1'b0, 32'h1111_2222, 32'h0);
        rs1_addr = 5'd0;
        #1;
        check("r0_no_bypass", rs1_data, 32'h0);
        tick();
        clear_inputs();
        #1;
        check("r0_stays_zero", rs1_data, 32'h0);

        // Test 2: load select.
        drive_write(5'd7, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
        tick();
        clear_inputs();
        rs2_addr = 5'd7;
        #1;
        check("load_r7", rs2_data, 32'h1234_5678);

        // Baseline values for r3 and r4.
        drive_write(5'd3, 1'b0, 32'hAAAA_0003, 32'h0);
        tick();
        drive_write(5'd4, 1'b0, 32'h4444_0004, 32'h0);
        tick();

        // Test 3: exception. It must not write r3 or bypass to it.
        drive_exc(32'h0000_0400, 32'h1000_0040, 5'd3);
        rs1_addr = 5'd3;
        rs2_addr = 5'd4;
        #1;
        check("exc_no_bypass_r3", rs1_data, 32'hAAAA_0003);
        tick();
        // Cycle N+1: FLUSH. A write to r4 is presented and must be squashed.
        check("exc_flush_c1", 32'(flush), 32'd1);
        check("exc_rv_c1", 32'(redirect_valid), 32'd1);
        check("exc_redirect_pc", redirect_pc, 32'h0000_8000);
        check("exc_epc", epc, 32'h0000_0400);
        check("exc_ebadaddr", ebadaddr, 32'h1000_0040);
        check("exc_supervisor", 32'(supervisor), 32'd1);
        drive_write(5'd4, 1'b0, 32'h5555_5555, 32'h0);
        #1;
        check("squash_no_bypass_r4", rs2_data, 32'h4444_0004);
        tick();
        // Cycle N+2: DRAIN. An exception presented now must not be captured.
        check("exc_flush_c2", 32'(flush), 32'd1);
        check("exc_rv_c2", 32'(redirect_valid), 32'd0);
        drive_exc(32'h0000_0999, 32'h0000_0777, 5'd4);
        tick();
        // Cycle N+3: last DRAIN cycle.
        check("exc_flush_c3", 32'(flush), 32'd1);
        check("exc_rv_c3", 32'(redirect_valid), 32'd0);
        check("squash_epc_stable", epc, 32'h0000_0400);
        check("squash_ebadaddr_stable", ebadaddr, 32'h1000_0040);
        drive_write(5'd4, 1'b0, 32'h6666_6666, 32'h0);
        tick();
        clear_inputs();
        #1;
        check("exc_flush_done", 32'(flush), 32'd0);
        check("r3_unchanged", rs1_data, 32'hAAAA_0003);
        check("r4_unchanged", rs2_data, 32'h4444_0004);
        check("sup_held_idle", 32'(supervisor), 32'd1);

        // Test 4: iret returns to epc.
        iret = 1'b1;
        tick();
        iret = 1'b0;
        check("iret_flush_c1", 32'(flush), 32'd1);
        check("iret_rv_c1", 32'(redirect_valid), 32'd1);
        check("iret_redirect_pc", redirect_pc, 32'h0000_0400);
        check("iret_supervisor", 32'(supervisor), 32'd0);
        tick();
        check("iret_flush_c2", 32'(flush), 32'd1);
        check("iret_rv_c2", 32'(redirect_valid), 32'd0);
        tick();
        check("iret_flush_c3", 32'(flush), 32'd1);
        tick();
        check("iret_flush_done", 32'(flush), 32'd0);
        // An iret in user mode is ignored.
        iret = 1'b1;
        tick();
        iret = 1'b0;
        check("iret_user_no_flush", 32'(flush), 32'd0);
        check("iret_user_no_rv", 32'(redirect_valid), 32'd0);

        // Test 5: enter supervisor mode, then exception and iret in the same cycle.
        drive_exc(32'h0000_0500, 32'h0000_2000, 5'd1);
        tick();
        clear_inputs();
        tick();
        tick();
        tick();
        check("coll_pre_idle", 32'(flush), 32'd0);
        check("coll_pre_sup", 32'(supervisor), 32'd1);
        drive_exc(32'h0000_0600, 32'h0000_3000, 5'd1);
        iret = 1'b1;
        tick();
        clear_inputs();
        check("coll_rv", 32'(redirect_valid), 32'd1);
        check("coll_redirect_pc", redirect_pc, 32'h0000_8000);
        check("coll_supervisor", 32'(supervisor), 32'd1);
        check("coll_epc", epc, 32'h0000_0600);
        check("coll_ebadaddr", ebadaddr, 32'h0000_3000);
        tick();
        tick();
        tick();
        check("coll_flush_done", 32'(flush), 32'd0);

        // Test 6: reset during DRAIN.
        drive_exc(32'h0000_0700, 32'h0000_4000, 5'd1);
        tick();
        clear_inputs();
        tick();
        check("rst_pre_drain_flush", 32'(flush), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_flush_immediate", 32'(flush), 32'd0);
        check("rst_supervisor", 32'(supervisor), 32'd0);
        check("rst_epc", epc, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        rs1_addr = 5'd5;
        rs2_addr = 5'd7;
        #1;
        check("rst_r5", rs1_data, 32'h0);
        check("rst_r7", rs2_data, 32'h0);
        #2;
        reset_n = 1'b1;
        tick();
        check("rst_idle_flush", 32'(flush), 32'd0);
        // The FSM must be back in IDLE, so a write is accepted.
        drive_write(5'd9, 1'b0, 32'hCAFE_0009, 32'h0);
        tick();
        clear_inputs();
        rs1_addr = 5'd9;
        #1;
        check("post_rst_write_r9", rs1_data, 32'hCAFE_0009);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
Writeback/commit stage directly downstream of the MEM/WB pipeline register. It holds the 32x32 architectural register file and retires one instruction per cycle, selecting load data or ALU result. It also handles precise exceptions:
- captures the faulting PC and address;
- enters supervisor mode;
- flushes the pipeline and redirects fetch to the handler;
- returns from the handler on an iret request.

Parameters:
HANDLER_VECTOR, 32'h0000_8000, fetch redirect target on exception
DRAIN_CYCLES, 3, total cycles flush stays asserted per redirect (>=1)

Ports:
clock  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
wb_valid  input  1  MEM/WB slot holds a real instruction
wb_result  input  32  ALU result
wb_read_data  input  32  load data from data cache
wb_rd  input  5  destination register
wb_mem_to_reg  input  1  1: write wb_read_data, 0: write wb_result
wb_reg_write  input  1  instruction writes rd
wb_exception  input  1  instruction raised exception (incl. dTLB miss)
wb_faulty_address  input  32  faulting address
wb_pc  input  32  PC of retiring instruction
iret  input  1  decode-stage return-from-exception request (single-cycle pulse)
rs1_addr  input  5  read port 1 address
rs2_addr  input  5  read port 2 address
rs1_data  output  32  read port 1 data
rs2_data  output  32  read port 2 data
flush  output  1  squash all younger pipeline stages
redirect_valid  output  1  fetch must load redirect_pc
redirect_pc  output  32  new fetch PC
epc  output  32  saved exception PC
ebadaddr  output  32  saved faulting address
supervisor  output  1  1 while in exception handler

Behaviour:
- Reset (async, reset_n=0): all 32 registers=0, epc=0, ebadaddr=0, supervisor=0, flush=0, redirect_valid=0, redirect_pc=0, FSM=IDLE, drain counter=0. Reset mid-drain aborts immediately.
- Write data: wb_mem_to_reg ? wb_read_data : wb_result.
- Register write at posedge when all of the following hold:
  - wb_valid=1, wb_reg_write=1, wb_exception=0, wb_rd!=0;
  - FSM=IDLE.
- r0 always reads 0 and is never written.
- Read ports: combinational. When a write is pending in the same cycle and rsN_addr==wb_rd (nonzero), write data is bypassed to rsN_data.
- Exception accept: wb_valid=1, wb_exception=1, FSM=IDLE. At the posedge:
  - epc<=wb_pc, ebadaddr<=wb_faulty_address, supervisor<=1;
  - no register write; FSM->FLUSH.
- iret accept: iret=1, supervisor=1, FSM=IDLE, and no exception accepted that cycle. At the posedge: supervisor<=0, FSM->FLUSH with redirect target epc.
- iret with supervisor=0 is ignored.
- Simultaneous exception and iret: the exception wins; iret is dropped.
- FSM:
  - IDLE: flush=0, redirect_valid=0.
  - FLUSH (1 cycle): flush=1, redirect_valid=1, redirect_pc = HANDLER_VECTOR (exception) or captured epc (iret). If DRAIN_CYCLES==1, next state is IDLE; otherwise DRAIN with counter=DRAIN_CYCLES-1.
  - DRAIN: flush=1, redirect_valid=0; counter decrements each cycle; at counter==1, next state is IDLE.
- Total flush high = DRAIN_CYCLES consecutive cycles; redirect_valid high exactly 1 cycle.
- Outside IDLE, incoming wb_valid instructions are squashed: no write, no exception capture. epc/ebadaddr are stable until the next accepted exception.
- Outputs flush, redirect_valid, redirect_pc, epc, ebadaddr and supervisor are registered.
- Latency: exception present at posedge N gives flush/redirect_valid high in cycle N+1.
- No nesting: an exception while supervisor=1 is still accepted. It overwrites epc/ebadaddr and redirects to HANDLER_VECTOR again.

Test Plan:
1. Write and bypass: wb_valid=1, reg_write=1, rd=5, mem_to_reg=0, result=32'hDEAD_BEEF, rs1_addr=5 in the same cycle.
   -> rs1_data=DEAD_BEEF combinationally; after the edge r5 reads DEAD_BEEF. Repeat with rd=0 -> r0 stays 0.
2. Load select: mem_to_reg=1, read_data=32'h1234_5678, result=32'hFFFF_FFFF, rd=7.
   -> r7=1234_5678.
3. Exception: wb_pc=32'h400, faulty_address=32'h1000_0040, wb_exception=1, reg_write=1, rd=3.
   -> r3 unchanged; next cycle epc=400, ebadaddr=1000_0040, supervisor=1, redirect_valid=1 with redirect_pc=8000 for 1 cycle; flush high 3 cycles.
   -> Valid instructions writing r4 during those 3 cycles are not written.
4. iret: after test 3 completes, pulse iret.
   -> redirect_pc=400, redirect_valid 1 cycle, flush 3 cycles, supervisor=0. iret pulsed with supervisor=0 -> no flush.
5. Collision: wb_exception and iret in the same cycle with supervisor=1.
   -> redirect_pc=8000, supervisor stays 1, epc updated.
6. Reset mid-drain: assert reset_n=0 during DRAIN.
   -> flush=0 immediately, all registers 0, supervisor=0, FSM=IDLE after release.
